// File: rtl/i2c_fifo_ctrl_pkg.sv
// Shared definitions for the I2C byte queues: depth derivation, default
// geometry of the TX/RX queues and the per-cycle control bundle.
package i2c_fifo_ctrl_pkg;

  localparam int unsigned TX_AW = 32'd4;
  localparam int unsigned TX_DW = 32'd8;
  localparam int unsigned RX_AW = 32'd4;
  localparam int unsigned RX_DW = 32'd8;

  typedef struct packed {
    logic clr;
    logic push;
    logic pop;
    logic fetch;
  } fifo_ctl_t;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/i2c_fifo_ctrl_if.sv
// Push/pop handshake bundle of the FIFO controller; master is the
// producer/consumer side, slave is the controller.
interface i2c_fifo_ctrl_if #(
  parameter int unsigned aw = 32'd4,
  parameter int unsigned dw = 32'd8
);

  logic          wr_valid;
  logic          wr_ready;
  logic [dw-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [dw-1:0] rd_data;
  logic [aw:0]   level;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level
  );

endinterface

// File: rtl/i2c_fifo_ctrl_chk.sv
// Structural invariants of the FIFO controller state.
module i2c_fifo_ctrl_chk #(
  parameter int unsigned aw = 32'd4
) (
  input logic          clk,
  input logic          rst,
  input logic [aw:0]   level,
  input logic          out_valid,
  input logic [aw-1:0] wptr,
  input logic [aw-1:0] fptr,
  input logic [aw:0]   avail
);

  localparam logic [aw:0] DEPTH_LVL = (aw+1)'(i2c_fifo_ctrl_pkg::fifo_depth(aw));

  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    level <= DEPTH_LVL);

  a_head_counted: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (level != '0));

  a_ptr_gap: assert property (@(posedge clk) disable iff (rst)
    (level < DEPTH_LVL) |-> ((wptr - fptr) == avail[aw-1:0]));

endmodule

// File: rtl/i2c_fifo_ctrl_ptr.sv
// aw-bit wrapping address counter with synchronous clear and increment
// enable; clear has priority over increment.
module i2c_fifo_ctrl_ptr #(
  parameter int unsigned aw = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [aw-1:0] ptr
);

  logic [aw-1:0] ptr_q;
  logic [aw-1:0] ptr_d;

  // next pointer value
  always_comb begin
    ptr_d = ptr_q;
    if (rst || clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{(aw-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/i2c_fifo_ctrl.sv
// First-word-fall-through byte queue controller driving an external dpram;
// the head is presented straight from the RAM read register.
module i2c_fifo_ctrl
  import i2c_fifo_ctrl_pkg::*;
#(
  parameter int unsigned aw = TX_AW,
  parameter int unsigned dw = TX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  i2c_fifo_ctrl_if.slave fif,
  output logic [aw-1:0] ram_waddr,
  output logic          ram_we,
  output logic          ram_wce,
  output logic [dw-1:0] ram_di,
  output logic [aw-1:0] ram_raddr,
  output logic          ram_rce,
  output logic          ram_oe,
  input  logic [dw-1:0] ram_do
);

  localparam logic [aw:0] DEPTH_LVL = (aw+1)'(fifo_depth(aw));

  logic [aw:0]   level_q;
  logic [aw:0]   level_d;
  logic          out_valid_q;
  logic          out_valid_d;
  logic [aw-1:0] wptr;
  logic [aw-1:0] fptr;
  logic [aw:0]   avail_s;
  logic          wr_ready_s;
  fifo_ctl_t     ctl_s;

  // handshake decode; a flush cycle accepts the handshake but drops the write
  always_comb begin
    ctl_s      = '0;
    wr_ready_s = !rst && (level_q != DEPTH_LVL);
    avail_s    = level_q - {{aw{1'b0}}, out_valid_q};
    ctl_s.clr  = rst || flush;
    ctl_s.push = fif.wr_valid && wr_ready_s && !flush;
    ctl_s.pop  = out_valid_q && fif.rd_ready;
    if (!rst && !flush && (avail_s != '0) && (!out_valid_q || ctl_s.pop)) begin
      ctl_s.fetch = 1'b1;
    end else begin
      ctl_s.fetch = 1'b0;
    end
  end

  // occupancy and head-presented next state
  always_comb begin
    level_d     = level_q;
    out_valid_d = out_valid_q;
    if (ctl_s.clr) begin
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      level_d = level_q + {{aw{1'b0}}, ctl_s.push} - {{aw{1'b0}}, ctl_s.pop};
      if (ctl_s.fetch) begin
        out_valid_d = 1'b1;
      end else if (ctl_s.pop) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    level_q     <= level_d;
    out_valid_q <= out_valid_d;
  end

  i2c_fifo_ctrl_ptr #(.aw(aw)) u_wptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (ctl_s.push),
    .ptr (wptr)
  );

  i2c_fifo_ctrl_ptr #(.aw(aw)) u_fptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (ctl_s.fetch),
    .ptr (fptr)
  );

  i2c_fifo_ctrl_chk #(.aw(aw)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .level     (level_q),
    .out_valid (out_valid_q),
    .wptr      (wptr),
    .fptr      (fptr),
    .avail     (avail_s)
  );

  assign fif.wr_ready = wr_ready_s;
  assign fif.rd_valid = out_valid_q;
  assign fif.rd_data  = ram_do;
  assign fif.level    = level_q;

  assign ram_waddr = wptr;
  assign ram_we    = ctl_s.push;
  assign ram_wce   = ctl_s.push;
  assign ram_di    = fif.wr_data;
  // the read address only advances on rce, which keeps a stalled head stable
  assign ram_raddr = fptr;
  assign ram_rce   = ctl_s.fetch;
  assign ram_oe    = 1'b1;

endmodule
